// File: rtl/loop_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | loop_ctrl_pkg                                                        |
// | State encoding and default sizing for the timing-loop gain scheduler |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package loop_ctrl_pkg;

  typedef enum logic [1:0] {
    LC_IDLE = 2'd0,
    LC_ACQ  = 2'd1,
    LC_TRK  = 2'd2
  } lc_state_t;

  localparam int LC_ERR_W       = 16;
  localparam int LC_GAIN_W      = 16;
  localparam int LC_WIN_LOG2    = 5;
  localparam int LC_LOCK_WINS   = 4;
  localparam int LC_UNLOCK_WINS = 2;
  localparam int LC_ACQ_TO_WINS = 64;

endpackage
`default_nettype wire

// File: rtl/win_mag_avg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | win_mag_avg                                                          |
// | Windowed mean of saturated |err| over 2^WIN_LOG2 accepted samples    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module win_mag_avg
  import loop_ctrl_pkg::*;
#(
  parameter int ERR_W    = LC_ERR_W,
  parameter int WIN_LOG2 = LC_WIN_LOG2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    smp_vld,
  input  logic signed [ERR_W-1:0] err,
  output logic                    win_done,
  output logic [ERR_W-1:0]        win_avg
);

  localparam int ACC_W = ERR_W + WIN_LOG2;
  localparam logic [ERR_W-1:0] NEG_MIN = {1'b1, {(ERR_W-1){1'b0}}};
  localparam logic [ERR_W-1:0] POS_MAX = {1'b0, {(ERR_W-1){1'b1}}};

  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [WIN_LOG2-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0]    mag;
  logic [ACC_W-1:0]    sum;

  always_comb begin
    // The most negative code has no positive twin, so it clamps to full scale
    if (!err[ERR_W-1]) begin
      mag = err;
    end else if (err == NEG_MIN) begin
      mag = POS_MAX;
    end else begin
      mag = -err;
    end

    sum      = acc_q + ACC_W'(mag);
    win_done = smp_vld && (cnt_q == '1);
    win_avg  = ERR_W'(sum >> WIN_LOG2);

    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (smp_vld) begin
      if (win_done) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/loop_gain_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | loop_gain_sched                                                      |
// | Acquisition/tracking gain scheduler driven by windowed mean |err|    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module loop_gain_sched
  import loop_ctrl_pkg::*;
#(
  parameter int ERR_W       = LC_ERR_W,
  parameter int GAIN_W      = LC_GAIN_W,
  parameter int WIN_LOG2    = LC_WIN_LOG2,
  parameter int LOCK_WINS   = LC_LOCK_WINS,
  parameter int UNLOCK_WINS = LC_UNLOCK_WINS,
  parameter int ACQ_TO_WINS = LC_ACQ_TO_WINS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    err_valid,
  input  logic signed [ERR_W-1:0] err,
  input  logic [GAIN_W-1:0]       kp_acq,
  input  logic [GAIN_W-1:0]       ki_acq,
  input  logic [GAIN_W-1:0]       kp_trk,
  input  logic [GAIN_W-1:0]       ki_trk,
  input  logic [ERR_W-1:0]        lock_thr,
  input  logic [ERR_W-1:0]        unlock_thr,
  output logic [GAIN_W-1:0]       kp,
  output logic [GAIN_W-1:0]       ki,
  output logic                    gain_upd,
  output logic                    integ_clr,
  output logic                    locked,
  output logic [1:0]              state
);

  localparam int GC_W = $clog2(LOCK_WINS + 1);
  localparam int BC_W = $clog2(UNLOCK_WINS + 1);
  localparam int TC_W = $clog2(ACQ_TO_WINS + 1);
  localparam logic [GC_W-1:0] LOCK_N   = GC_W'(LOCK_WINS);
  localparam logic [BC_W-1:0] UNLOCK_N = BC_W'(UNLOCK_WINS);
  localparam logic [TC_W-1:0] TO_N     = TC_W'(ACQ_TO_WINS);

  lc_state_t         state_q, state_d;
  logic [GAIN_W-1:0] kp_q, kp_d, ki_q, ki_d;
  logic              gain_upd_q, gain_upd_d;
  logic              integ_clr_q, integ_clr_d;
  logic              locked_q, locked_d;
  logic [GC_W-1:0]   good_q, good_d, good_inc;
  logic [BC_W-1:0]   bad_q, bad_d, bad_inc;
  logic [TC_W-1:0]   to_q, to_d, to_inc;

  logic              smp_vld;
  logic              win_clr;
  logic              win_done;
  logic [ERR_W-1:0]  win_avg;
  logic              win_good;
  logic              win_bad;

  assign smp_vld = err_valid && en && (state_q != LC_IDLE);
  assign win_clr = !en || (state_q == LC_IDLE);

  win_mag_avg #(
    .ERR_W    (ERR_W),
    .WIN_LOG2 (WIN_LOG2)
  ) u_win (
    .clk      (clk),
    .reset    (reset),
    .clr      (win_clr),
    .smp_vld  (smp_vld),
    .err      (err),
    .win_done (win_done),
    .win_avg  (win_avg)
  );

  // Hysteresis: an average equal to either threshold is neither good nor bad
  assign win_good = win_avg < lock_thr;
  assign win_bad  = win_avg > unlock_thr;
  assign good_inc = good_q + 1'b1;
  assign bad_inc  = bad_q + 1'b1;
  assign to_inc   = to_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    kp_d        = kp_q;
    ki_d        = ki_q;
    locked_d    = locked_q;
    gain_upd_d  = 1'b0;
    integ_clr_d = 1'b0;
    good_d      = good_q;
    bad_d       = bad_q;
    to_d        = to_q;

    if (!en) begin
      state_d  = LC_IDLE;
      kp_d     = '0;
      ki_d     = '0;
      locked_d = 1'b0;
      good_d   = '0;
      bad_d    = '0;
      to_d     = '0;
    end else begin
      case (state_q)
        LC_IDLE: begin
          state_d     = LC_ACQ;
          kp_d        = kp_acq;
          ki_d        = ki_acq;
          gain_upd_d  = 1'b1;
          integ_clr_d = 1'b1;
          good_d      = '0;
          bad_d       = '0;
          to_d        = '0;
        end
        LC_ACQ: begin
          if (win_done) begin
            // Lock wins over a coinciding acquisition timeout
            if (win_good && (good_inc == LOCK_N)) begin
              state_d    = LC_TRK;
              kp_d       = kp_trk;
              ki_d       = ki_trk;
              gain_upd_d = 1'b1;
              locked_d   = 1'b1;
              good_d     = '0;
              bad_d      = '0;
              to_d       = '0;
            end else if (to_inc == TO_N) begin
              integ_clr_d = 1'b1;
              good_d      = '0;
              to_d        = '0;
            end else begin
              good_d = win_good ? good_inc : '0;
              to_d   = to_inc;
            end
          end
        end
        LC_TRK: begin
          if (win_done) begin
            if (win_bad && (bad_inc == UNLOCK_N)) begin
              state_d    = LC_ACQ;
              kp_d       = kp_acq;
              ki_d       = ki_acq;
              gain_upd_d = 1'b1;
              locked_d   = 1'b0;
              good_d     = '0;
              bad_d      = '0;
              to_d       = '0;
            end else begin
              bad_d = win_bad ? bad_inc : '0;
            end
          end
        end
        default: begin
          state_d  = LC_IDLE;
          kp_d     = '0;
          ki_d     = '0;
          locked_d = 1'b0;
          good_d   = '0;
          bad_d    = '0;
          to_d     = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= LC_IDLE;
      kp_q        <= '0;
      ki_q        <= '0;
      gain_upd_q  <= 1'b0;
      integ_clr_q <= 1'b0;
      locked_q    <= 1'b0;
      good_q      <= '0;
      bad_q       <= '0;
      to_q        <= '0;
    end else begin
      state_q     <= state_d;
      kp_q        <= kp_d;
      ki_q        <= ki_d;
      gain_upd_q  <= gain_upd_d;
      integ_clr_q <= integ_clr_d;
      locked_q    <= locked_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      to_q        <= to_d;
    end
  end

  assign kp        = kp_q;
  assign ki        = ki_q;
  assign gain_upd  = gain_upd_q;
  assign integ_clr = integ_clr_q;
  assign locked    = locked_q;
  assign state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_loop_gain_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_loop_gain_sched                                                   |
// | Randomized directed bench against a window-level reference model     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_loop_gain_sched;

  localparam int WIN         = 32;
  localparam int LOCK_WINS   = 4;
  localparam int UNLOCK_WINS = 2;
  localparam int ACQ_TO_WINS = 64;

  logic               clk = 1'b0;
  logic               reset;
  logic               en;
  logic               err_valid;
  logic signed [15:0] err;
  logic [15:0]        kp_acq, ki_acq, kp_trk, ki_trk;
  logic [15:0]        lock_thr, unlock_thr;
  logic [15:0]        kp, ki;
  logic               gain_upd, integ_clr, locked;
  logic [1:0]         state;

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_st, m_kp, m_ki, m_gu, m_ic, m_lk;
  int m_good, m_bad, m_acqw;
  int m_q[$];

  always #5 clk = ~clk;

  loop_gain_sched #(
    .ERR_W       (16),
    .GAIN_W      (16),
    .WIN_LOG2    (5),
    .LOCK_WINS   (LOCK_WINS),
    .UNLOCK_WINS (UNLOCK_WINS),
    .ACQ_TO_WINS (ACQ_TO_WINS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .err_valid  (err_valid),
    .err        (err),
    .kp_acq     (kp_acq),
    .ki_acq     (ki_acq),
    .kp_trk     (kp_trk),
    .ki_trk     (ki_trk),
    .lock_thr   (lock_thr),
    .unlock_thr (unlock_thr),
    .kp         (kp),
    .ki         (ki),
    .gain_upd   (gain_upd),
    .integ_clr  (integ_clr),
    .locked     (locked),
    .state      (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic m_clear_counts();
    m_good = 0;
    m_bad  = 0;
    m_acqw = 0;
    m_q.delete();
  endtask

  task automatic m_reset();
    m_st = 0; m_kp = 0; m_ki = 0; m_gu = 0; m_ic = 0; m_lk = 0;
    m_clear_counts();
  endtask

  // One clock edge of the behavioural model, using the inputs present at it
  task automatic m_edge();
    int e, a, s, avg;
    m_gu = 0;
    m_ic = 0;
    if (reset) begin
      m_reset();
      return;
    end
    if (!en) begin
      m_st = 0; m_kp = 0; m_ki = 0; m_lk = 0;
      m_clear_counts();
      return;
    end
    if (m_st == 0) begin
      m_st = 1; m_kp = int'(kp_acq); m_ki = int'(ki_acq); m_gu = 1; m_ic = 1;
      m_clear_counts();
      return;
    end
    if (!err_valid) return;
    e = int'(err);
    a = (e < 0) ? -e : e;
    if (a > 32767) a = 32767;
    m_q.push_back(a);
    if (m_q.size() < WIN) return;
    s = 0;
    foreach (m_q[i]) s += m_q[i];
    avg = s / WIN;
    m_q.delete();
    if (m_st == 1) begin
      m_good = (avg < int'(lock_thr)) ? m_good + 1 : 0;
      m_acqw++;
      if (m_good == LOCK_WINS) begin
        m_st = 2; m_kp = int'(kp_trk); m_ki = int'(ki_trk); m_gu = 1; m_lk = 1;
        m_clear_counts();
      end else if (m_acqw == ACQ_TO_WINS) begin
        m_ic = 1; m_acqw = 0; m_good = 0;
      end
    end else begin
      m_bad = (avg > int'(unlock_thr)) ? m_bad + 1 : 0;
      if (m_bad == UNLOCK_WINS) begin
        m_st = 1; m_kp = int'(kp_acq); m_ki = int'(ki_acq); m_gu = 1; m_lk = 0;
        m_clear_counts();
      end
    end
  endtask

  task automatic check_all();
    chk("state",     32'(state),     32'(m_st));
    chk("kp",        32'(kp),        32'(m_kp));
    chk("ki",        32'(ki),        32'(m_ki));
    chk("gain_upd",  32'(gain_upd),  32'(m_gu));
    chk("integ_clr", 32'(integ_clr), 32'(m_ic));
    chk("locked",    32'(locked),    32'(m_lk));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    m_edge();
    check_all();
  endtask

  // Deliver n accepted samples of random sign and magnitude in [lo,hi];
  // single-cycle gaps are inserted at random but never back to back.
  task automatic feed(input int n, input int lo, input int hi);
    int got;
    int mag;
    bit gap;
    got = 0;
    gap = 1'b0;
    while (got < n) begin
      gap = !gap && ($urandom_range(0, 3) == 0);
      err_valid = !gap;
      mag = int'($urandom_range(lo, hi));
      err = ($urandom_range(0, 1) == 1) ? 16'(-mag) : 16'(mag);
      if (!gap) got++;
      tick();
    end
    err_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; err_valid = 1'b0; err = '0;
    kp_acq = 16'h1111; ki_acq = 16'h0222;
    kp_trk = 16'h0333; ki_trk = 16'h0044;
    lock_thr = 16'd100; unlock_thr = 16'd200;
    m_reset();

    tick();
    tick();
    chk("reset_state", 32'(state), 0);
    reset = 1'b0;
    tick();

    // acquisition entry and lock after 128 samples of |err|=50
    en = 1'b1;
    tick();
    chk("acq_entry_state", 32'(state), 1);
    chk("acq_entry_gu",    32'(gain_upd), 1);
    chk("acq_entry_ic",    32'(integ_clr), 1);
    feed(127, 50, 50);
    chk("prelock_locked", 32'(locked), 0);
    feed(1, 50, 50);
    chk("lock_locked", 32'(locked), 1);
    chk("lock_kp",     32'(kp), 32'h0333);

    // gain config changes mid-state are not picked up
    kp_trk = 16'hBEEF;
    feed(64, 50, 50);
    chk("latched_kp", 32'(kp), 32'h0333);
    kp_trk = 16'h0333;

    // unlock after exactly 64 samples of |err|=300
    feed(63, 300, 300);
    chk("preunlock_locked", 32'(locked), 1);
    feed(1, 300, 300);
    chk("unlock_locked", 32'(locked), 0);
    chk("unlock_state",  32'(state), 1);
    chk("unlock_kp",     32'(kp), 32'h1111);
    chk("unlock_ic",     32'(integ_clr), 0);

    // acquisition timeout every 2048 samples in the hysteresis band
    for (int k = 0; k < 2; k++) begin
      feed(2047, 150, 150);
      chk("pre_timeout_ic", 32'(integ_clr), 0);
      feed(1, 150, 150);
      chk("timeout_ic",     32'(integ_clr), 1);
      chk("timeout_locked", 32'(locked), 0);
    end

    // random bursts across the thresholds, model-checked every cycle
    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 2))
        0:       feed(32 * int'($urandom_range(1, 6)), 0, 120);
        1:       feed(32 * int'($urandom_range(1, 6)), 150, 400);
        default: feed(32 * int'($urandom_range(1, 6)), 90, 210);
      endcase
    end

    // saturated -32768 input must average to 32767 without wrapping
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    feed(128, 50, 50);
    chk("sat_pre_locked", 32'(locked), 1);
    unlock_thr = 16'd32767;
    feed(64, 32768, 32768);
    chk("sat_eq_locked", 32'(locked), 1);
    unlock_thr = 16'd32766;
    feed(64, 32768, 32768);
    chk("sat_bad_locked", 32'(locked), 0);
    chk("sat_bad_state",  32'(state), 1);
    unlock_thr = 16'd200;

    // en dropped on the last sample of the locking window
    feed(127, 50, 50);
    en = 1'b0; err_valid = 1'b1; err = 16'sd50;
    tick();
    chk("endrop_state",  32'(state), 0);
    chk("endrop_kp",     32'(kp), 0);
    chk("endrop_ki",     32'(ki), 0);
    chk("endrop_gu",     32'(gain_upd), 0);
    chk("endrop_locked", 32'(locked), 0);
    err_valid = 1'b0;
    en = 1'b1;
    tick();
    chk("reen_gu", 32'(gain_upd), 1);

    // reset mid-window in tracking, then a full fresh lock
    feed(128, 50, 50);
    chk("pre_rst_locked", 32'(locked), 1);
    feed(10, 50, 50);
    reset = 1'b1;
    #1;
    m_reset();
    chk("rst_state",  32'(state), 0);
    chk("rst_kp",     32'(kp), 0);
    chk("rst_ki",     32'(ki), 0);
    chk("rst_gu",     32'(gain_upd), 0);
    chk("rst_ic",     32'(integ_clr), 0);
    chk("rst_locked", 32'(locked), 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_state", 32'(state), 1);
    chk("post_rst_gu",    32'(gain_upd), 1);
    feed(127, 50, 50);
    chk("post_rst_prelock", 32'(locked), 0);
    feed(1, 50, 50);
    chk("post_rst_lock", 32'(locked), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
